// File: rtl/rr_arb10_pkg.sv
// Shared constants, state type and index helpers
// for the 10-way round-robin arbiter.
package rr_arb10_pkg;

  localparam int N_REQ = 10;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] ptr_inc(
    input logic [SEL_W-1:0] p
  );
    return (p == SEL_W'(N_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lowest circular offset from ptr wins, so scan
  // offsets high to low and let the last hit stand.
  function automatic logic [SEL_W-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [SEL_W-1:0] ptr
  );
    logic [SEL_W:0]   j;
    logic [SEL_W-1:0] k;
    k = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = {1'b0, ptr} + (SEL_W + 1)'(i);
      if (j >= (SEL_W + 1)'(N_REQ))
        j = j - (SEL_W + 1)'(N_REQ);
      if (req[j[SEL_W-1:0]])
        k = j[SEL_W-1:0];
    end
    return k;
  endfunction

endpackage

// File: rtl/rr_arb10_mux10.sv
// 10:1 W-bit data selector.
// Out-of-range selects yield zero.
module mux10
  import rr_arb10_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic [W-1:0]     d2,
  input  logic [W-1:0]     d3,
  input  logic [W-1:0]     d4,
  input  logic [W-1:0]     d5,
  input  logic [W-1:0]     d6,
  input  logic [W-1:0]     d7,
  input  logic [W-1:0]     d8,
  input  logic [W-1:0]     d9,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     y
);

  always_comb begin
    y = '0;
    unique case (sel)
      4'd0:    y = d0;
      4'd1:    y = d1;
      4'd2:    y = d2;
      4'd3:    y = d3;
      4'd4:    y = d4;
      4'd5:    y = d5;
      4'd6:    y = d6;
      4'd7:    y = d7;
      4'd8:    y = d8;
      4'd9:    y = d9;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb10.sv
// Round-robin arbiter: 10 requesters into one
// registered output slot with valid/ready.
module rr_arb10
  import rr_arb10_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] REQ,
  input  logic [W-1:0]     I0,
  input  logic [W-1:0]     I1,
  input  logic [W-1:0]     I2,
  input  logic [W-1:0]     I3,
  input  logic [W-1:0]     I4,
  input  logic [W-1:0]     I5,
  input  logic [W-1:0]     I6,
  input  logic [W-1:0]     I7,
  input  logic [W-1:0]     I8,
  input  logic [W-1:0]     I9,
  output logic [N_REQ-1:0] GNT,
  output logic [W-1:0]     Z,
  output logic             Z_VALID,
  input  logic             Z_READY,
  output logic [SEL_W-1:0] S
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] k;
  logic [W-1:0]     sel_d;
  logic             slot_free;
  logic             grant;

  assign k         = rr_pick(REQ, ptr);
  assign slot_free = (state == IDLE) || Z_READY;
  assign grant     = !rst && slot_free && |REQ;
  assign GNT       = grant ? (N_REQ'(1) << k) : '0;
  assign Z_VALID   = (state == FULL);

  mux10 #(.W(W)) u_mux (
    .d0  (I0),
    .d1  (I1),
    .d2  (I2),
    .d3  (I3),
    .d4  (I4),
    .d5  (I5),
    .d6  (I6),
    .d7  (I7),
    .d8  (I8),
    .d9  (I9),
    .sel (k),
    .y   (sel_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Z     <= '0;
      S     <= '0;
      ptr   <= '0;
    end else if (grant) begin
      state <= FULL;
      Z     <= sel_d;
      S     <= k;
      ptr   <= ptr_inc(k);
    end else if (state == FULL && Z_READY) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_rr_arb10.sv
// Directed and random stimulus for rr_arb10
// against a circular-search reference model.
module tb_rr_arb10;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [9:0]   req;
  logic [W-1:0] din [10];
  logic         zr;
  logic [9:0]   gnt;
  logic [W-1:0] z;
  logic         zv;
  logic [3:0]   s;

  int errors = 0;
  int checks = 0;

  // reference state
  bit       m_known = 0;
  bit       m_full;
  int       m_z;
  int       m_s;
  int       m_ptr;
  logic [9:0] last_gnt;

  always #5 clk = ~clk;

  rr_arb10 #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .REQ     (req),
    .I0      (din[0]),
    .I1      (din[1]),
    .I2      (din[2]),
    .I3      (din[3]),
    .I4      (din[4]),
    .I5      (din[5]),
    .I6      (din[6]),
    .I7      (din[7]),
    .I8      (din[8]),
    .I9      (din[9]),
    .GNT     (gnt),
    .Z       (z),
    .Z_VALID (zv),
    .Z_READY (zr),
    .S       (s)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    int idx;
    for (int o = 0; o < 10; o++) begin
      idx = (m_ptr + o) % 10;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  // check at negedge, advance one edge, update model
  task automatic step();
    int  k;
    bit  free;
    logic [9:0] eg;
    @(negedge clk);
    free = !rst && (!m_full || zr) && (req != 0);
    k  = -1;
    eg = '0;
    if (free && m_known) begin
      k  = model_pick();
      eg = 10'(1) << k;
    end
    last_gnt = gnt;
    if (m_known || rst) chk("gnt", 32'(gnt), 32'(eg));
    if (m_known) begin
      chk("z_valid", 32'(zv), 32'(m_full));
      chk("z", 32'(z), 32'(m_z));
      chk("s", 32'(s), 32'(m_s));
    end
    @(posedge clk);
    if (rst) begin
      m_known = 1;
      m_full  = 0;
      m_z     = 0;
      m_s     = 0;
      m_ptr   = 0;
    end else if (k >= 0) begin
      m_full = 1;
      m_z    = int'(din[k]);
      m_s    = k;
      m_ptr  = (k + 1) % 10;
    end else if (m_full && zr) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    req = '0;
    zr  = 1;
    for (int i = 0; i < 10; i++) din[i] = '0;
    step();
    chk("rst_zv", 32'(zv), 0);
    chk("rst_z", 32'(z), 0);
    chk("rst_s", 32'(s), 0);
    rst = 0;

    // reset while holding a word
    req = 10'h001; din[0] = 8'h5A; zr = 0;
    step();
    chk("hold_5a", 32'(z), 32'h5A);
    rst = 1; req = 10'h3FF;
    step();
    chk("mid_rst_gnt", 32'(last_gnt), 0);
    chk("mid_rst_zv", 32'(zv), 0);
    chk("mid_rst_z", 32'(z), 0);
    chk("mid_rst_s", 32'(s), 0);
    rst = 0; req = 10'h200; din[9] = 8'h99;
    step();
    chk("post_rst_gnt", 32'(last_gnt), 32'h200);
    chk("post_rst_s", 32'(s), 9);

    // single request
    do_reset();
    req = 10'h008; din[3] = 8'hA5; zr = 1;
    step();
    chk("single_gnt", 32'(last_gnt), 32'h008);
    chk("single_z", 32'(z), 32'hA5);
    chk("single_s", 32'(s), 3);
    chk("single_zv", 32'(zv), 1);
    req = '0;
    step();
    chk("single_idle", 32'(zv), 0);

    // full round robin, no bubbles
    do_reset();
    for (int i = 0; i < 10; i++) din[i] = W'(i);
    req = 10'h3FF; zr = 1;
    for (int i = 0; i < 11; i++) begin
      step();
      chk("rr_z", 32'(z), 32'(i % 10));
      chk("rr_zv", 32'(zv), 1);
    end

    // backpressure
    do_reset();
    req = 10'h011; zr = 1; din[0] = 8'h10; din[4] = 8'h44;
    step();
    chk("bp_first_s", 32'(s), 0);
    zr = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_gnt", 32'(last_gnt), 0);
      chk("bp_z", 32'(z), 32'h10);
    end
    zr = 1;
    step();
    chk("bp_gnt4", 32'(last_gnt), 32'h010);
    chk("bp_s4", 32'(s), 4);

    // wrap-around
    req = 10'h200;
    step();
    chk("wrap_s9", 32'(s), 9);
    req = 10'h201;
    step();
    chk("wrap_g0", 32'(last_gnt), 32'h001);
    step();
    chk("wrap_g9", 32'(last_gnt), 32'h200);

    // drain
    req = '0;
    step();
    chk("drain_zv", 32'(zv), 0);
    chk("drain_s", 32'(s), 9);
    chk("drain_z", 32'(z), 32'(din[9]));

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      zr  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       req = '0;
        1:       req = 10'(1) << $urandom_range(0, 9);
        default: req = 10'($urandom);
      endcase
      for (int i = 0; i < 10; i++) din[i] = W'($urandom);
      step();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arb10.md
RR_ARB10 -- requirements
Module: rr_arb10

Interface
REQ-001 W  default 8  data width of each requester lane and of the output; the only parameter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 REQ  input  10  per-requester valid; bit k means I<k> holds a word to send.
REQ-005 I0..I9  input  W each  requester data; stable while the matching REQ bit is high.
REQ-006 GNT  output  10  one-hot accept, combinational; bit k high means I<k> is captured at this edge.
REQ-007 Z  output  W  registered output data word.
REQ-008 Z_VALID  output  1  Z holds an unconsumed word.
REQ-009 Z_READY  input  1  consumer accepts Z at any edge where Z_VALID and Z_READY are both high.
REQ-010 S  output  4  registered index of the requester whose word is in Z; range 0..9.

Function
REQ-011 The state machine SHALL have two states: IDLE (Z empty) and FULL (Z_VALID=1).
REQ-012 The output slot is "free" in IDLE, or in FULL when Z_READY=1.
REQ-013 When the slot is free and REQ!=0, the block SHALL select index k.
  - k is the first set REQ bit, searching circularly from PTR upward, 9 wrapping to 0.
REQ-014 In that cycle, the block SHALL set GNT to one-hot bit k, and at the edge:
  - Z <= I<k>; S <= k; Z_VALID <= 1; state FULL;
  - PTR <= k+1, with 9 wrapping to 0.
REQ-015 GNT SHALL be all-zero whenever the slot is not free or REQ=0.
REQ-016 If FULL, Z_READY=1 and REQ=0, the block SHALL go to IDLE with Z_VALID <= 0; Z and S hold their values.
REQ-017 If FULL and Z_READY=0, Z, S, Z_VALID and PTR SHALL hold unchanged, regardless of REQ.
REQ-018 Simultaneous consume and grant in FULL SHALL sustain one word per cycle with no bubble.
REQ-019 Latency: REQ high at edge t with a free slot gives Z_VALID=1 and Z=I<k> after edge t.
REQ-020 PTR SHALL advance only on a grant.
  - Fairness: a continuously requesting lane waits at most 9 grants.
REQ-021 REQ bits for indices 10..15 do not exist; S SHALL never take values 10..15.
REQ-022 Data selection SHALL be purely by index k.
  - Data on a lane whose REQ bit is low is ignored.

Reset
REQ-023 While rst=1 at a rising edge, the block SHALL load:
  - state IDLE, Z_VALID=0, Z=0, S=0, PTR=0.
REQ-024 GNT SHALL be all-zero in any cycle in which rst=1.
REQ-025 Reset mid-transfer SHALL discard the word held in Z.
  - No GNT is issued during reset.
  - The first grant after reset searches from index 0.

Structure
REQ-026 A shared package SHALL hold:
  - constants N_REQ=10 and SEL_W=4;
  - the state enum {IDLE, FULL};
  - the circular-increment function used for PTR.
REQ-027 Data selection SHALL use one instance of the existing 10:1 W-bit selector sub-module, mux10.
  - Its select is the combinational k.
  - Its output feeds the Z register.
REQ-028 The priority search SHALL be a single combinational function of REQ and PTR.
  - No extra pipeline stage.

Verification
REQ-029 Reset mid-FULL: rst=1 while Z_VALID=1, Z=0x5A.
  - Next cycle: Z_VALID=0, Z=0, S=0, GNT=0.
  - Then REQ=0x200 grants lane 9.
REQ-030 Single request: REQ=0x008, I3=0xA5, Z_READY=1.
  - GNT=0x008 that cycle.
  - Next cycle: Z=0xA5, S=3, Z_VALID=1.
  - Then IDLE once REQ drops.
REQ-031 Round-robin: REQ=0x3FF held, Z_READY=1, I<k>=k.
  - Z sequence 0,1,...,9,0.
  - One grant per cycle, no bubbles.
REQ-032 Backpressure: Z_READY=0 for 5 cycles with REQ=0x011.
  - Z, S hold; GNT=0.
  - After Z_READY=1, lane 4 is granted next.
  - PTR was 1 after granting lane 0.
REQ-033 Wrap-around: after a grant to lane 9, REQ=0x201 → lane 0 granted before lane 9.
REQ-034 Drain: Z_READY=1 with REQ=0 while FULL.
  - Z_VALID=0 next cycle; S and Z hold.
